// File: rtl/fproc_meas_sched_if.sv
// rtl/fproc_meas_sched_if.sv - measurement/core request bus for fproc_meas_sched
// master drives measurements and core requests; slave (the scheduler) returns responses.
interface fproc_meas_sched_if #(
  parameter int N_CORES = 5,
  parameter int N_MEAS  = N_CORES,
  parameter int ID_W    = 8
);
  logic [N_MEAS-1:0]       meas;
  logic [N_MEAS-1:0]       meas_valid;
  logic [N_CORES-1:0]      core_enable;
  logic [N_CORES*ID_W-1:0] core_id;
  logic [N_CORES-1:0]      core_ready;
  logic [N_CORES-1:0]      core_data;
  logic [N_CORES-1:0]      core_err;

  modport master (
    output meas, meas_valid, core_enable, core_id,
    input  core_ready, core_data, core_err
  );

  modport slave (
    input  meas, meas_valid, core_enable, core_id,
    output core_ready, core_data, core_err
  );
endinterface

// File: rtl/fproc_meas_sched.sv
// rtl/fproc_meas_sched.sv - round-robin scheduler returning measurement bits to requesting cores
// FPROC_MEAS_WAIT_FRESH_EN: when defined, a request waits (bounded by TIMEOUT) for a strobe newer than itself.
module fproc_meas_sched #(
  parameter int N_CORES = 5,
  parameter int N_MEAS  = N_CORES,
  parameter int ID_W    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  fproc_meas_sched_if.slave   bus
);
  localparam int GW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [N_CORES-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]      id_q [N_CORES];
  logic [ID_W-1:0]      id_d [N_CORES];
  logic [N_MEAS-1:0]    meas_reg_q, meas_reg_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic [N_CORES-1:0]   ready_q, ready_d;
  logic [N_CORES-1:0]   data_q, data_d;
  logic [N_CORES-1:0]   err_q, err_d;
`ifdef FPROC_MEAS_WAIT_FRESH_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [N_CORES-1:0]   seen_q, seen_d;
  logic [CW-1:0]        cnt_q, cnt_d;
`endif

  logic [ID_W-1:0]      g_id;
  logic                 g_in_range;
  logic                 g_meas;
  logic                 found;
  logic [GW-1:0]        cand;

  // Channel lookup for the granted core; out-of-range ids read as 0.
  always_comb begin
    g_id       = id_q[grant_q];
    g_in_range = (g_id < ID_W'(N_MEAS));
    g_meas     = 1'b0;
    for (int m = 0; m < N_MEAS; m++) begin
      if (g_id == ID_W'(m)) g_meas = meas_reg_q[m];
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    id_d         = id_q;
    meas_reg_d   = meas_reg_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;
    ready_d      = '0;
    data_d       = '0;
    err_d        = '0;
    found        = 1'b0;
    cand         = '0;
`ifdef FPROC_MEAS_WAIT_FRESH_EN
    seen_d       = seen_q;
    cnt_d        = cnt_q;
`endif

    for (int m = 0; m < N_MEAS; m++) begin
      if (bus.meas_valid[m]) meas_reg_d[m] = bus.meas[m];
    end

    for (int c = 0; c < N_CORES; c++) begin
`ifdef FPROC_MEAS_WAIT_FRESH_EN
      for (int m = 0; m < N_MEAS; m++) begin
        if (pending_q[c] && id_q[c] == ID_W'(m) && bus.meas_valid[m]) seen_d[c] = 1'b1;
      end
`endif
      if (bus.core_enable[c] && !pending_q[c]) begin
        pending_d[c] = 1'b1;
        id_d[c]      = bus.core_id[c*ID_W +: ID_W];
`ifdef FPROC_MEAS_WAIT_FRESH_EN
        seen_d[c]    = 1'b0;
`endif
      end
    end

    case (state_q)
      IDLE: begin
        for (int k = 1; k <= N_CORES; k++) begin
          cand = GW'((int'(last_grant_q) + k) % N_CORES);
          if (!found && pending_q[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) state_d = READ;
      end
      READ: begin
        if (!g_in_range) begin
          res_err_d  = 1'b1;
          res_data_d = 1'b0;
          state_d    = RESP;
        end else begin
`ifdef FPROC_MEAS_WAIT_FRESH_EN
          if (seen_q[grant_q]) begin
            res_err_d  = 1'b0;
            res_data_d = g_meas;
            state_d    = RESP;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
`else
          res_err_d  = 1'b0;
          res_data_d = g_meas;
          state_d    = RESP;
`endif
        end
      end
`ifdef FPROC_MEAS_WAIT_FRESH_EN
      WAIT: begin
        // A strobe landing in the timeout cycle still counts as a good result.
        if (seen_q[grant_q]) begin
          res_err_d  = 1'b0;
          res_data_d = g_meas;
          state_d    = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_err_d  = 1'b1;
          res_data_d = g_meas;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RESP: begin
        ready_d[grant_q]   = 1'b1;
        data_d[grant_q]    = res_data_q;
        err_d[grant_q]     = res_err_q;
        pending_d[grant_q] = 1'b0;
        last_grant_d       = grant_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      id_q         <= '{default: '0};
      meas_reg_q   <= '0;
      last_grant_q <= GW'(N_CORES - 1);
      grant_q      <= '0;
      res_data_q   <= 1'b0;
      res_err_q    <= 1'b0;
      ready_q      <= '0;
      data_q       <= '0;
      err_q        <= '0;
`ifdef FPROC_MEAS_WAIT_FRESH_EN
      seen_q       <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      id_q         <= id_d;
      meas_reg_q   <= meas_reg_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      err_q        <= err_d;
`ifdef FPROC_MEAS_WAIT_FRESH_EN
      seen_q       <= seen_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.core_ready = ready_q;
  assign bus.core_data  = data_q;
  assign bus.core_err   = err_q;
endmodule

// File: tb/tb_fproc_meas_sched.sv
// tb/tb_fproc_meas_sched.sv - self-checking bench for fproc_meas_sched
// Covers FPROC_MEAS_WAIT_FRESH_EN in both settings.
module tb_fproc_meas_sched;
  localparam int NC = 5;
  localparam int NM = 5;
  localparam int IW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fproc_meas_sched_if #(.N_CORES(NC), .N_MEAS(NM), .ID_W(IW)) bus ();
  fproc_meas_sched #(.N_CORES(NC), .N_MEAS(NM), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;
  int last_grant = NC - 1;
  logic [NM-1:0] meas_model = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, 32'(bus.core_ready), 32'd0);
    chk({tag, " data"},  32'(bus.core_data),  32'd0);
    chk({tag, " err"},   32'(bus.core_err),   32'd0);
  endtask

  task automatic strobe(input logic [NM-1:0] mask, input logic [NM-1:0] val);
    bus.meas_valid = mask;
    bus.meas       = val;
    tick();
    for (int m = 0; m < NM; m++) if (mask[m]) meas_model[m] = val[m];
    bus.meas_valid = '0;
    bus.meas       = '0;
  endtask

  // Simultaneous requests are served in round-robin order from last_grant+1, one every 3 cycles.
  task automatic run_batch(input string tag, input logic [NC-1:0] en, input logic [NC*IW-1:0] ids);
    int order[$];
    int c;
    logic [IW-1:0] id;
    logic [NC-1:0] er, ed, ee;
    for (int j = 1; j <= NC; j++) begin
      c = (last_grant + j) % NC;
      if (en[c]) order.push_back(c);
    end
    bus.core_enable = en;
    bus.core_id     = ids;
    tick();
    bus.core_enable = '0;
    for (int t = 1; t <= 3 * order.size() + 1; t++) begin
      tick();
      er = '0; ed = '0; ee = '0;
      if (t % 3 == 0 && t / 3 <= order.size()) begin
        c = order[t/3-1];
        id = ids[c*IW +: IW];
        er[c] = 1'b1;
        ee[c] = (id >= IW'(NM));
        ed[c] = (id < IW'(NM)) ? meas_model[id[2:0]] : 1'b0;
      end
      chk($sformatf("%s ready t%0d", tag, t), 32'(bus.core_ready), 32'(er));
      chk($sformatf("%s data t%0d", tag, t),  32'(bus.core_data),  32'(ed));
      chk($sformatf("%s err t%0d", tag, t),   32'(bus.core_err),   32'(ee));
    end
    if (order.size() > 0) last_grant = order[order.size()-1];
  endtask

  function automatic logic [NC*IW-1:0] one_id(input int core, input logic [IW-1:0] id);
    logic [NC*IW-1:0] v;
    v = '0;
    v[core*IW +: IW] = id;
    return v;
  endfunction

  initial begin
    int got, n_ready;
    logic [NC-1:0] d_at, e_at;
    logic [NC-1:0] en;
    logic [NC*IW-1:0] ids;

    reset = 1'b0;
    bus.meas = '0; bus.meas_valid = '0; bus.core_enable = '0; bus.core_id = '0;
    repeat (3) tick();
    chk_idle("reset");
    reset = 1'b1;
    tick();
    chk_idle("post reset");

    run_batch("oob id7", 5'b10000, one_id(4, 8'd7));

`ifdef FPROC_MEAS_WAIT_FRESH_EN
    // Fresh strobe arrives while core 1 waits on channel 4.
    bus.core_enable = 5'b00010; bus.core_id = one_id(1, 8'd4);
    tick();
    bus.core_enable = '0;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("fresh quiet", 32'(bus.core_ready), 32'd0);
    end
    strobe(5'b10000, 5'b10000);
    got = -1;
    for (int t = 1; t <= 4 && got < 0; t++) begin
      tick();
      if (bus.core_ready != '0) got = t;
    end
    chk("fresh latency", 32'(got), 32'd2);
    chk("fresh ready", 32'(bus.core_ready), 32'h2);
    chk("fresh data",  32'(bus.core_data),  32'h2);
    chk("fresh err",   32'(bus.core_err),   32'h0);
    last_grant = 1;
    tick();

    // Timeout with stale data; a second enable while pending is ignored.
    strobe(5'b01001, 5'b01000);
    bus.core_enable = 5'b00010; bus.core_id = one_id(1, 8'd3);
    tick();
    got = -1; n_ready = 0; d_at = '0; e_at = '0;
    for (int t = 1; t <= 40; t++) begin
      if (t == 4) begin
        bus.core_enable = 5'b00010; bus.core_id = one_id(1, 8'd0);
      end else begin
        bus.core_enable = '0;
      end
      tick();
      if (bus.core_ready != '0) begin
        n_ready++;
        if (got < 0) begin got = t; d_at = bus.core_data; e_at = bus.core_err; end
      end
    end
    chk("timeout latency", 32'(got), 32'd19);
    chk("timeout data", 32'(d_at), 32'h2);
    chk("timeout err", 32'(e_at), 32'h2);
    chk("timeout single resp", 32'(n_ready), 32'd1);
    last_grant = 1;

    // Reset while waiting aborts the transaction.
    bus.core_enable = 5'b00100; bus.core_id = one_id(2, 8'd0);
    tick();
    bus.core_enable = '0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk_idle("wait reset");
    tick();
    reset = 1'b1;
    meas_model = '0; last_grant = NC - 1;
    for (int t = 0; t < 25; t++) begin
      tick();
      chk("wait reset quiet", 32'(bus.core_ready), 32'd0);
    end
    run_batch("after wait reset", 5'b00100, one_id(2, 8'd7));
`else
    // Contention from last_grant=N_CORES-1: 0, 1, 3 served at +3, +6, +9.
    strobe(5'b11111, 5'b01010);
    ids = one_id(0, 8'd0) | one_id(1, 8'd1) | one_id(3, 8'd3);
    last_grant = NC - 1;
    tick();
    reset = 1'b0; tick(); reset = 1'b1; tick();
    meas_model = '0;
    strobe(5'b11111, 5'b01010);
    run_batch("contend", 5'b01011, ids);

    strobe(5'b00100, 5'b00100);
    run_batch("no wait", 5'b00001, one_id(0, 8'd2));

    // Reset mid-transaction: no response, next request served normally.
    bus.core_enable = 5'b00100; bus.core_id = one_id(2, 8'd1);
    tick();
    bus.core_enable = '0;
    tick();
    reset = 1'b0;
    #1;
    chk_idle("mid reset");
    tick();
    chk_idle("mid reset hold");
    reset = 1'b1;
    meas_model = '0; last_grant = NC - 1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("mid reset quiet", 32'(bus.core_ready), 32'd0);
    end
    strobe(5'b00010, 5'b00010);
    run_batch("after reset", 5'b00100, one_id(2, 8'd1));

    for (int r = 0; r < 12; r++) begin
      strobe(5'b11111, NM'($urandom));
      en = NC'($urandom_range(1, (1 << NC) - 1));
      ids = '0;
      for (int c = 0; c < NC; c++) ids[c*IW +: IW] = IW'($urandom_range(0, 7));
      run_batch($sformatf("rand%0d", r), en, ids);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
